// File: rtl/iod_delay_line_ctrl.sv
// ============================================================================
// iod_delay_line_ctrl - sequences MOVE/LOAD pulses onto IOD delay-line lanes;
// tap tracking/clamping enabled by IOD_DLY_TAP_TRACK_EN.           Rev 1.0
// ============================================================================
`default_nettype none

module iod_delay_line_ctrl #(
  parameter int NUM_LANES     = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int TAP_W         = 8,
  parameter int LOAD_TAP      = 1,
  localparam int LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 fab_clk,
  input  logic                 sync_rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LANE_W-1:0]    req_lane,
  input  logic [1:0]           req_op,
  input  logic [7:0]           req_steps,
  output logic                 done,
  output logic [1:0]           status,
  output logic [7:0]           done_steps,
  output logic                 busy,
  output logic [NUM_LANES-1:0] delay_line_move,
  output logic [NUM_LANES-1:0] delay_line_direction,
  output logic [NUM_LANES-1:0] delay_line_load,
  input  logic [NUM_LANES-1:0] delay_line_out_of_range,
  input  logic [LANE_W-1:0]    tap_sel,
  output logic [TAP_W-1:0]     tap_value
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] c_op_load = 2'b00;
  localparam logic [1:0] c_op_inc  = 2'b01;
  localparam logic [1:0] c_op_dec  = 2'b10;

  localparam logic [1:0] c_st_ok    = 2'b00;
  localparam logic [1:0] c_st_oor   = 2'b01;
  localparam logic [1:0] c_st_clamp = 2'b10;
  localparam logic [1:0] c_st_err   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_PULSE  = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          w_status_nxt;
  logic [LANE_W-1:0]   r_lane;
  logic [1:0]          r_op;
  logic                r_err;
  logic [7:0]          r_steps_left;
  logic [7:0]          r_issued;
  logic [SW-1:0]       r_settle;
  logic [NUM_LANES-1:0] r_dir;
  logic [1:0]          r_status;
  logic [7:0]          r_done_steps;
  logic [NUM_LANES-1:0] w_lane_bit;
  logic                w_xfer, w_lane_ok, w_oor, w_clamp, w_is_move;

  assign w_xfer    = req_valid && (r_state == S_IDLE);
  assign w_lane_ok = ({1'b0, req_lane} < (LANE_W+1)'(NUM_LANES));
  assign w_oor     = delay_line_out_of_range[r_lane];
  assign w_is_move = (req_op == c_op_inc) || (req_op == c_op_dec);

`ifdef IOD_DLY_TAP_TRACK_EN
  localparam logic [TAP_W-1:0] c_max_tap = '1;
  logic [TAP_W-1:0] r_tap [NUM_LANES];

  // Next pulse would run the tracked tap past either end of the line.
  assign w_clamp = ((r_op == c_op_inc) && (r_tap[r_lane] == c_max_tap)) ||
                   ((r_op == c_op_dec) && (r_tap[r_lane] == '0));

  always_ff @(posedge fab_clk) begin
    if (sync_rst) begin
      for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= TAP_W'(LOAD_TAP);
    end else if (r_state == S_PULSE) begin
      case (r_op)
        c_op_load: r_tap[r_lane] <= TAP_W'(LOAD_TAP);
        c_op_inc:  r_tap[r_lane] <= r_tap[r_lane] + 1'b1;
        c_op_dec:  r_tap[r_lane] <= r_tap[r_lane] - 1'b1;
        default:   ;
      endcase
    end
  end

  assign tap_value = ({1'b0, tap_sel} < (LANE_W+1)'(NUM_LANES)) ? r_tap[tap_sel] : '0;
`else
  logic w_unused_ok;
  assign w_clamp     = 1'b0;
  assign tap_value   = '0;
  assign w_unused_ok = ^{tap_sel, LOAD_TAP[0]};
`endif

  always_ff @(posedge fab_clk) begin
    if (sync_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = c_st_ok;
    case (r_state)
      S_IDLE:   if (w_xfer) w_state_nxt = S_SETUP;
      S_SETUP: begin
        if (r_err) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = c_st_err;
        end else if (r_op == c_op_load) begin
          w_state_nxt = S_PULSE;
        end else if (r_steps_left == 8'd0) begin
          w_state_nxt = S_DONE;
        end else if (w_clamp) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = c_st_clamp;
        end else begin
          w_state_nxt = S_PULSE;
        end
      end
      S_PULSE:  w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_settle == '0) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_oor) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = c_st_oor;
        end else if (r_steps_left != 8'd0) begin
          if (w_clamp) begin
            w_state_nxt  = S_DONE;
            w_status_nxt = c_st_clamp;
          end else begin
            w_state_nxt = S_PULSE;
          end
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge fab_clk) begin
    if (sync_rst) begin
      r_lane       <= '0;
      r_op         <= '0;
      r_err        <= 1'b0;
      r_steps_left <= '0;
      r_issued     <= '0;
      r_settle     <= '0;
      r_dir        <= '0;
      r_status     <= '0;
      r_done_steps <= '0;
    end else begin
      if (w_xfer) begin
        r_lane       <= req_lane;
        r_op         <= req_op;
        r_err        <= (req_op == 2'b11) || !w_lane_ok;
        r_steps_left <= (req_op == c_op_load) ? 8'd0 : req_steps;
        r_issued     <= '0;
        // Direction is presented during SETUP, so it is captured at transfer.
        if (w_is_move && w_lane_ok) r_dir[req_lane] <= (req_op == c_op_inc);
      end
      if (r_state == S_PULSE) begin
        r_settle <= SW'(SETTLE_CYCLES - 1);
        if (r_op != c_op_load) begin
          r_steps_left <= r_steps_left - 8'd1;
          r_issued     <= r_issued + 8'd1;
        end
      end else if ((r_state == S_SETTLE) && (r_settle != '0)) begin
        r_settle <= r_settle - 1'b1;
      end
      r_status     <= (w_state_nxt == S_DONE) ? w_status_nxt : '0;
      r_done_steps <= (w_state_nxt == S_DONE) ? r_issued : '0;
    end
  end

  always_comb begin
    w_lane_bit         = '0;
    w_lane_bit[r_lane] = 1'b1;
  end

  assign delay_line_move      = ((r_state == S_PULSE) && (r_op != c_op_load)) ? w_lane_bit : '0;
  assign delay_line_load      = ((r_state == S_PULSE) && (r_op == c_op_load)) ? w_lane_bit : '0;
  assign delay_line_direction = r_dir;
  assign req_ready            = (r_state == S_IDLE);
  assign busy                 = (r_state != S_IDLE);
  assign done                 = (r_state == S_DONE);
  assign status               = r_status;
  assign done_steps           = r_done_steps;

endmodule

`default_nettype wire

// File: tb/tb_iod_delay_line_ctrl.sv
// ============================================================================
// tb_iod_delay_line_ctrl - directed scoreboard bench for iod_delay_line_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_iod_delay_line_ctrl;

`ifdef IOD_DLY_TAP_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [0:0] req_lane = '0;
  logic [1:0] req_op = '0;
  logic [7:0] req_steps = '0;
  logic       done;
  logic [1:0] status;
  logic [7:0] done_steps;
  logic       busy;
  logic [1:0] mv, dir, ld;
  logic [1:0] oor = '0;
  logic [0:0] tap_sel = '0;
  logic [7:0] tap_value;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] st;
    logic [7:0] steps;
    int         lat;
    int         moves;
    int         loads;
  } exp_t;
  exp_t sb[$];

  iod_delay_line_ctrl #(
    .NUM_LANES(2), .SETTLE_CYCLES(2), .TAP_W(8), .LOAD_TAP(1)
  ) dut (
    .fab_clk                 (clk),
    .sync_rst                (rst),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_lane                (req_lane),
    .req_op                  (req_op),
    .req_steps               (req_steps),
    .done                    (done),
    .status                  (status),
    .done_steps              (done_steps),
    .busy                    (busy),
    .delay_line_move         (mv),
    .delay_line_direction    (dir),
    .delay_line_load         (ld),
    .delay_line_out_of_range (oor),
    .tap_sel                 (tap_sel),
    .tap_value               (tap_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, watches the DUT until DONE, then scores against the queue head.
  task automatic run(input string tag, input logic [0:0] lane, input logic [1:0] op,
                     input logic [7:0] steps, input logic [1:0] st, input logic [7:0] dsteps,
                     input int lat, input int moves, input int loads, input int oor_at);
    exp_t e;
    int cyc, n_mv, n_ld, stray, first, done_cyc;
    logic seen, rdy_at_done;
    logic [1:0] lane_bit, got_st;
    logic [7:0] got_steps;
    e.st = st; e.steps = dsteps; e.lat = lat; e.moves = moves; e.loads = loads;
    sb.push_back(e);
    lane_bit = 2'b01 << lane;
    req_lane = lane; req_op = op; req_steps = steps; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    cyc = 1; n_mv = 0; n_ld = 0; stray = 0; first = -1; seen = 1'b0; done_cyc = -1;
    got_st = '0; got_steps = '0; rdy_at_done = 1'b1;
    chk({tag, " busy@1"}, busy, 1);
    if (op == 2'b01 || op == 2'b10) chk({tag, " dir@1"}, dir[lane], (op == 2'b01));
    while (cyc <= 200 && !seen) begin
      if (cyc == oor_at) oor[lane] = 1'b1;
      if (mv[lane]) begin n_mv++; if (first < 0) first = cyc; end
      if (ld[lane]) begin n_ld++; if (first < 0) first = cyc; end
      if ((mv & ~lane_bit) != 0 || (ld & ~lane_bit) != 0) stray++;
      if (done) begin
        seen = 1'b1; done_cyc = cyc; got_st = status; got_steps = done_steps;
        rdy_at_done = req_ready;
      end else begin
        step();
        cyc++;
      end
    end
    oor = '0;
    e = sb.pop_front();
    chk({tag, " done seen"}, seen, 1);
    chk({tag, " latency"}, done_cyc, e.lat);
    chk({tag, " status"}, got_st, e.st);
    chk({tag, " done_steps"}, got_steps, e.steps);
    chk({tag, " moves"}, n_mv, e.moves);
    chk({tag, " loads"}, n_ld, e.loads);
    chk({tag, " stray pulses"}, stray, 0);
    chk({tag, " ready@done"}, rdy_at_done, 0);
    if (e.moves + e.loads > 0) chk({tag, " first pulse"}, first, 2);
    step();
    chk({tag, " ready after"}, req_ready, 1);
    chk({tag, " done 1 cycle"}, done, 0);
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    step();
    chk("rst ready", req_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pulses", {mv, ld}, 0);
    chk("rst dir", dir, 0);
    chk("rst status", {status, done_steps}, 0);
    tap_sel = 1'b1;
    chk("rst tap", tap_value, TRACK ? 1 : 0);

    run("inc l1 x3", 1'b1, 2'b01, 8'd3, 2'b00, 8'd3, 14, 3, 0, -1);
    chk("inc l1 tap", tap_value, TRACK ? 4 : 0);
    tap_sel = 1'b0;
    run("inc l0 x2", 1'b0, 2'b01, 8'd2, 2'b00, 8'd2, 10, 2, 0, -1);
    chk("inc l0 tap", tap_value, TRACK ? 3 : 0);
    run("dec oor", 1'b0, 2'b10, 8'd5, 2'b01, 8'd2, 10, 2, 0, 6);
    chk("dec oor tap", tap_value, TRACK ? 1 : 0);
    run("load l0", 1'b0, 2'b00, 8'd7, 2'b00, 8'd0, 6, 0, 1, -1);
    chk("load tap", tap_value, TRACK ? 1 : 0);
    chk("load dir kept", dir, 2'b10);
    run("dec to 0", 1'b0, 2'b10, 8'd1, 2'b00, 8'd1, 6, 1, 0, -1);
    chk("dec to 0 tap", tap_value, 0);
    run("dec at 0", 1'b0, 2'b10, 8'd1, TRACK ? 2'b10 : 2'b00, TRACK ? 8'd0 : 8'd1,
        TRACK ? 2 : 6, TRACK ? 0 : 1, 0, -1);
    run("op11", 1'b1, 2'b11, 8'd3, 2'b11, 8'd0, 2, 0, 0, -1);
    chk("op11 dir kept", dir, 2'b10);
    run("inc x0", 1'b1, 2'b01, 8'd0, 2'b00, 8'd0, 2, 0, 0, -1);

    // Reset wins over a transfer presented on the same edge.
    req_lane = 1'b0; req_op = 2'b01; req_steps = 8'd1;
    req_valid = 1'b1; rst = 1'b1;
    step();
    req_valid = 1'b0; rst = 1'b0;
    chk("rst prio busy", busy, 0);
    step();
    chk("rst prio idle", busy, 0);

    // Reset during cycle 7 of a 4-step INC.
    req_lane = 1'b0; req_op = 2'b01; req_steps = 8'd4; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    begin
      int dn = 0;
      for (int c = 1; c < 7; c++) begin
        if (done) dn++;
        step();
      end
      rst = 1'b1;
      step();
      chk("midrst pulses", {mv, ld}, 0);
      chk("midrst busy", busy, 0);
      chk("midrst dir", dir, 0);
      chk("midrst done", done, 0);
      rst = 1'b0;
      step();
      chk("midrst ready", req_ready, 1);
      chk("midrst no done", dn + int'(done), 0);
    end
    run("post rst inc", 1'b0, 2'b01, 8'd1, 2'b00, 8'd1, 6, 1, 0, -1);
    chk("post rst tap", tap_value, TRACK ? 2 : 0);
    chk("sb empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
